// File: rtl/gmii_tx_sched_pkg.sv
// Shared definitions for the GMII transmit scheduler.
// PKT_VIDEO / PKT_AUDIO match the packet-ID byte the transmitter puts on the
// wire, so the scheduler's pcktinfo bit is simply bit 0 of those codes.
package gmii_tx_sched_pkg;
  localparam int ADE_W = 4;

  localparam logic [7:0] PKT_VIDEO = 8'h00;
  localparam logic [7:0] PKT_AUDIO = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;
endpackage

// File: rtl/gmii_tx_sched_policy.sv
// Audio/video arbitration policy.
//   arm           : scheduler is idle and enabled; a decision here is a grant
//   clr           : frame finished, clear the latched packet description
//   vid_line_rdy  : video line buffered
//   aux_ade_avail : complete ADEs pending
//   dec_vld/dec_aud : combinational grant this cycle, and whether it is audio
//   pcktinfo/ade_num: packet description registered on the grant edge
module gmii_tx_sched_policy
  import gmii_tx_sched_pkg::*;
#(
  parameter logic [3:0]  MAX_ADE       = 4'd8,
  parameter logic [3:0]  AUD_MIN_ADE   = 4'd4,
  parameter logic [15:0] AUD_TIMEOUT   = 16'd20000,
  parameter logic [7:0]  MAX_VID_BURST = 8'd4
) (
  input  logic             tx_clk,
  input  logic             sys_rst,
  input  logic             arm,
  input  logic             clr,
  input  logic             vid_line_rdy,
  input  logic [4:0]       aux_ade_avail,
  output logic             dec_vld,
  output logic             dec_aud,
  output logic             pcktinfo,
  output logic [ADE_W-1:0] ade_num
);
  logic [15:0]      aud_age;
  logic [7:0]       vid_burst;
  logic             ade_pend, aged, aud_req, aud_win, vid_win;
  logic [ADE_W-1:0] ade_cap;

  always_comb begin
    ade_pend = (aux_ade_avail != 5'd0);
    aged     = (aud_age == AUD_TIMEOUT);
    aud_req  = (aux_ade_avail >= {1'b0, AUD_MIN_ADE}) | (ade_pend & aged);
    // Video normally wins; audio takes over when video is absent, the video
    // burst limit is hit, or the oldest ADE has aged out.
    aud_win  = aud_req & (~vid_line_rdy | (vid_burst >= MAX_VID_BURST) | aged);
    vid_win  = ~aud_win & vid_line_rdy;
    dec_vld  = arm & (aud_win | vid_win);
    dec_aud  = arm & aud_win;
    ade_cap  = (aux_ade_avail > {1'b0, MAX_ADE}) ? MAX_ADE : aux_ade_avail[3:0];
  end

  always_ff @(posedge tx_clk) begin
    if (sys_rst) begin
      aud_age   <= '0;
      vid_burst <= '0;
      pcktinfo  <= 1'b0;
      ade_num   <= '0;
    end else begin
      if (!ade_pend || dec_aud)       aud_age <= '0;
      else if (!aged)                 aud_age <= aud_age + 16'd1;

      if (!ade_pend || dec_aud)                   vid_burst <= '0;
      else if (dec_vld && vid_burst != 8'hff)     vid_burst <= vid_burst + 8'd1;

      if (dec_vld) begin
        pcktinfo <= dec_aud ? PKT_AUDIO[0] : PKT_VIDEO[0];
        ade_num  <= dec_aud ? ade_cap : '0;
      end else if (clr) begin
        pcktinfo <= 1'b0;
        ade_num  <= '0;
      end
    end
  end
endmodule

// File: rtl/gmii_tx_sched.sv
// Frame scheduler in front of the GMII transmitter: picks video line or audio
// AUX packet per frame, hands out send_enable and follows the frame via tx_en.
//   tx_clk, sys_rst (sync, active high), sched_en, vid_line_rdy, aux_ade_avail,
//   tx_en (transmitter feedback)
//   send_enable, pcktinfo, ade_num, busy, start_err (sticky),
//   vid_pkt_cnt / aud_pkt_cnt (granted packets, wrapping)
module gmii_tx_sched
  import gmii_tx_sched_pkg::*;
#(
  parameter logic [3:0]  MAX_ADE       = 4'd8,
  parameter logic [3:0]  AUD_MIN_ADE   = 4'd4,
  parameter logic [15:0] AUD_TIMEOUT   = 16'd20000,
  parameter logic [7:0]  MAX_VID_BURST = 8'd4,
  parameter logic [15:0] START_TIMEOUT = 16'd1024,
  parameter logic [7:0]  GAP_CYCLES    = 8'd4
) (
  input  logic             tx_clk,
  input  logic             sys_rst,
  input  logic             sched_en,
  input  logic             vid_line_rdy,
  input  logic [4:0]       aux_ade_avail,
  input  logic             tx_en,
  output logic             send_enable,
  output logic             pcktinfo,
  output logic [ADE_W-1:0] ade_num,
  output logic             busy,
  output logic             start_err,
  output logic [15:0]      vid_pkt_cnt,
  output logic [15:0]      aud_pkt_cnt
);
  state_t      state, state_n;
  logic        tx_en_q, rise, fall;
  logic        arm, clr, to_hit, dec_vld, dec_aud;
  logic [15:0] wait_cnt;
  logic [7:0]  gap_cnt;

  assign rise = tx_en & ~tx_en_q;
  assign fall = ~tx_en & tx_en_q;
  assign arm  = (state == S_IDLE) & sched_en;

  gmii_tx_sched_policy #(
    .MAX_ADE       (MAX_ADE),
    .AUD_MIN_ADE   (AUD_MIN_ADE),
    .AUD_TIMEOUT   (AUD_TIMEOUT),
    .MAX_VID_BURST (MAX_VID_BURST)
  ) u_policy (
    .tx_clk        (tx_clk),
    .sys_rst       (sys_rst),
    .arm           (arm),
    .clr           (clr),
    .vid_line_rdy  (vid_line_rdy),
    .aux_ade_avail (aux_ade_avail),
    .dec_vld       (dec_vld),
    .dec_aud       (dec_aud),
    .pcktinfo      (pcktinfo),
    .ade_num       (ade_num)
  );

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    to_hit  = 1'b0;
    case (state)
      S_IDLE:  if (dec_vld) state_n = S_GRANT;
      // rise is checked before the timeout so a start in the last cycle counts
      S_GRANT: begin
        if (rise) state_n = S_BUSY;
        else if (wait_cnt == START_TIMEOUT - 16'd1) begin
          state_n = S_IDLE;
          to_hit  = 1'b1;
        end
      end
      S_BUSY: begin
        if (fall) begin
          state_n = S_GAP;
          clr     = 1'b1;
        end
      end
      S_GAP:   if (gap_cnt == GAP_CYCLES - 8'd1) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      tx_en_q     <= 1'b0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      start_err   <= 1'b0;
      vid_pkt_cnt <= '0;
      aud_pkt_cnt <= '0;
    end else begin
      state     <= state_n;
      tx_en_q   <= tx_en;
      wait_cnt  <= (state == S_GRANT) ? wait_cnt + 16'd1 : '0;
      gap_cnt   <= (state == S_GAP)   ? gap_cnt + 8'd1   : '0;
      if (to_hit) start_err <= 1'b1;
      if (dec_vld && dec_aud)  aud_pkt_cnt <= aud_pkt_cnt + 16'd1;
      if (dec_vld && !dec_aud) vid_pkt_cnt <= vid_pkt_cnt + 16'd1;
    end
  end

  assign send_enable = (state == S_GRANT);
  assign busy        = (state != S_IDLE);
endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched: video stream, burst limit, audio cap,
// audio aging, start timeout and reset during a frame.
module tb_gmii_tx_sched;
  logic        tx_clk = 1'b0;
  logic        sys_rst, sched_en, vid_line_rdy, tx_en;
  logic [4:0]  aux_ade_avail;
  logic        send_enable, pcktinfo, busy, start_err;
  logic [3:0]  ade_num;
  logic [15:0] vid_pkt_cnt, aud_pkt_cnt;

  int n_chk = 0;
  int n_bad = 0;

  gmii_tx_sched dut (
    .tx_clk        (tx_clk),
    .sys_rst       (sys_rst),
    .sched_en      (sched_en),
    .vid_line_rdy  (vid_line_rdy),
    .aux_ade_avail (aux_ade_avail),
    .tx_en         (tx_en),
    .send_enable   (send_enable),
    .pcktinfo      (pcktinfo),
    .ade_num       (ade_num),
    .busy          (busy),
    .start_err     (start_err),
    .vid_pkt_cnt   (vid_pkt_cnt),
    .aud_pkt_cnt   (aud_pkt_cnt)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // all driving and sampling happens 1 time unit after the rising edge
  task automatic step();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, output int n);
    n = 0;
    while (!send_enable && n < 30000) begin
      step();
      n++;
    end
    if (!send_enable) chk({tag, "_tmo"}, send_enable, 1);
  endtask

  // transmitter model: start 3 cycles after the grant, hold tx_en for `hold`
  task automatic frame(input string tag, input int hold);
    repeat (3) step();
    tx_en = 1'b1;
    step();
    chk({tag, "_se_drop"}, send_enable, 0);
    chk({tag, "_busy"}, busy, 1);
    repeat (hold - 1) step();
    tx_en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    logic       exp_pk [6];
    logic [3:0] exp_ade[6];
    exp_pk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_ade = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 4'd0};

    sys_rst = 1'b1; sched_en = 1'b0; vid_line_rdy = 1'b0;
    aux_ade_avail = 5'd0; tx_en = 1'b0;
    repeat (3) step();
    chk("rst_se", send_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", start_err, 0);
    chk("rst_vcnt", vid_pkt_cnt, 0);
    chk("rst_acnt", aud_pkt_cnt, 0);
    sys_rst = 1'b0; sched_en = 1'b1;
    step();

    // video only: fall registered (1) + GAP (4) + decision (1) = 6 cycles
    vid_line_rdy = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_grant("vid", n);
      if (f > 0) chk("vid_gap", n, 6);
      chk("vid_pk", pcktinfo, 0);
      chk("vid_ade", ade_num, 0);
      frame("vid", 1350);
      if (f == 4) vid_line_rdy = 1'b0;
    end
    repeat (6) step();
    chk("vid_cnt", vid_pkt_cnt, 5);
    chk("vid_idle", busy, 0);

    // burst limit: four videos, then audio with 6 ADEs, then video again
    aux_ade_avail = 5'd6; vid_line_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      wait_grant("bur", n);
      chk($sformatf("bur_pk%0d", f), pcktinfo, exp_pk[f]);
      chk($sformatf("bur_ade%0d", f), ade_num, exp_ade[f]);
      frame("bur", 100);
      if (f == 5) begin
        vid_line_rdy = 1'b0;
        aux_ade_avail = 5'd0;
      end
    end
    repeat (8) step();
    chk("bur_acnt", aud_pkt_cnt, 1);
    chk("bur_vcnt", vid_pkt_cnt, 10);

    // cap: 20 pending gives 8, and later changes do not touch ade_num
    aux_ade_avail = 5'd20;
    wait_grant("cap", n);
    chk("cap_lat", n, 1);
    chk("cap_pk", pcktinfo, 1);
    chk("cap_ade", ade_num, 8);
    repeat (3) step();
    tx_en = 1'b1;
    step();
    aux_ade_avail = 5'd3;
    repeat (10) step();
    chk("cap_hold_ade", ade_num, 8);
    chk("cap_hold_pk", pcktinfo, 1);
    repeat (50) step();
    tx_en = 1'b0; aux_ade_avail = 5'd0;
    step();
    chk("gap_clr_ade", ade_num, 0);
    chk("gap_clr_pk", pcktinfo, 0);
    chk("gap_busy", busy, 1);
    repeat (8) step();
    chk("cap_acnt", aud_pkt_cnt, 2);

    // aging: one ADE, no video; aud_age hits 20000 after 20000 edges, grant next
    aux_ade_avail = 5'd1;
    wait_grant("age", n);
    chk("age_lat", n, 20001);
    chk("age_pk", pcktinfo, 1);
    chk("age_ade", ade_num, 1);
    frame("age", 20);
    aux_ade_avail = 5'd0;
    repeat (8) step();
    chk("age_acnt", aud_pkt_cnt, 3);

    // start timeout: tx_en never rises
    vid_line_rdy = 1'b1;
    wait_grant("sto", n);
    chk("sto_lat", n, 1);
    chk("sto_err0", start_err, 0);
    hi = 1;
    step();
    while (send_enable && hi < 2000) begin
      hi++;
      step();
    end
    chk("sto_len", hi, 1024);
    chk("sto_err", start_err, 1);
    chk("sto_idle", busy, 0);
    chk("sto_vcnt", vid_pkt_cnt, 11);
    step();
    chk("sto_regrant", send_enable, 1);
    chk("sto_vcnt2", vid_pkt_cnt, 12);

    // reset in BUSY
    tx_en = 1'b1;
    step();
    chk("mid_busy", busy, 1);
    chk("mid_se", send_enable, 0);
    repeat (5) step();
    sys_rst = 1'b1;
    step();
    chk("mrst_se", send_enable, 0);
    chk("mrst_pk", pcktinfo, 0);
    chk("mrst_ade", ade_num, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", start_err, 0);
    chk("mrst_vcnt", vid_pkt_cnt, 0);
    chk("mrst_acnt", aud_pkt_cnt, 0);
    sys_rst = 1'b0; tx_en = 1'b0; vid_line_rdy = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
